pipelined_datapath: RTL

Parametrised, two-stage pipelined successor to the single-cycle processor datapath. It accepts one command per cycle over a valid/ready handshake and executes it against a 2-read/1-write register file, an ALU with a status-flag register, and a synchronous data memory. Write-back results are forwarded so back-to-back dependent commands never stall. It sits between the control unit and the data memory/register file, and replaces direct per-cycle control of the datapath.

---
 rtl/pipelined_datapath_pkg.sv | 32 +++
 rtl/pipelined_datapath_if.sv | 52 +++++
 rtl/pipelined_datapath_rf.sv | 38 +++
 rtl/pipelined_datapath.sv | 227 ++++++++++++++++++++++
 4 files changed

// File: rtl/pipelined_datapath_pkg.sv
// -----------------------------------------------------------------------------
// datapath_pkg
// Shared types for the two-stage pipelined datapath: command opcodes, ALU
// function codes and the bit positions of the {N,Z,C,V} status flags.
// -----------------------------------------------------------------------------
package datapath_pkg;

  typedef enum logic [1:0] {
    OP_LDI   = 2'd0,
    OP_ALU   = 2'd1,
    OP_LOAD  = 2'd2,
    OP_STORE = 2'd3
  } cmd_op_t;

  typedef enum logic [2:0] {
    ALU_PASS = 3'd0,
    ALU_ADD  = 3'd1,
    ALU_SUB  = 3'd2,
    ALU_AND  = 3'd3,
    ALU_OR   = 3'd4,
    ALU_XOR  = 3'd5,
    ALU_NOT  = 3'd6,
    ALU_INC  = 3'd7
  } alu_op_t;

  localparam int FLAGS_W = 4;
  localparam int FLAG_N  = 3;
  localparam int FLAG_Z  = 2;
  localparam int FLAG_C  = 1;
  localparam int FLAG_V  = 0;

endpackage

// File: rtl/pipelined_datapath_if.sv
// -----------------------------------------------------------------------------
// pipelined_datapath_if
// Command and status bundle between the control unit (master) and the
// pipelined datapath (slave).
//   Cmd_valid/Cmd_ready  command handshake; Hold freezes the whole pipeline
//   Cmd_op, Imm, D_Addr, RF_*_Addr, ALU_s0   command payload
//   ALU_inA/ALU_inB/ALU_out   E-stage operands (after forwarding) and result
//   Flags                     registered {N,Z,C,V}
//   Wb_valid/Wb_addr/Wb_data  W-stage register-file write
// -----------------------------------------------------------------------------
interface pipelined_datapath_if
  import datapath_pkg::*;
#(
  parameter int DATA_W = 16,
  parameter int RA_W   = 4,
  parameter int MA_W   = 8
) ();

  logic                Cmd_valid;
  logic                Cmd_ready;
  logic                Hold;
  cmd_op_t             Cmd_op;
  logic [DATA_W-1:0]   Imm;
  logic [MA_W-1:0]     D_Addr;
  logic [RA_W-1:0]     RF_W_Addr;
  logic [RA_W-1:0]     RF_Ra_Addr;
  logic [RA_W-1:0]     RF_Rb_Addr;
  alu_op_t             ALU_s0;

  logic [DATA_W-1:0]   ALU_inA;
  logic [DATA_W-1:0]   ALU_inB;
  logic [DATA_W-1:0]   ALU_out;
  logic [FLAGS_W-1:0]  Flags;
  logic                Wb_valid;
  logic [RA_W-1:0]     Wb_addr;
  logic [DATA_W-1:0]   Wb_data;

  modport master (
    output Cmd_valid, Hold, Cmd_op, Imm, D_Addr, RF_W_Addr, RF_Ra_Addr,
           RF_Rb_Addr, ALU_s0,
    input  Cmd_ready, ALU_inA, ALU_inB, ALU_out, Flags, Wb_valid, Wb_addr,
           Wb_data
  );

  modport slave (
    input  Cmd_valid, Hold, Cmd_op, Imm, D_Addr, RF_W_Addr, RF_Ra_Addr,
           RF_Rb_Addr, ALU_s0,
    output Cmd_ready, ALU_inA, ALU_inB, ALU_out, Flags, Wb_valid, Wb_addr,
           Wb_data
  );

endinterface

// File: rtl/pipelined_datapath_rf.sv
// -----------------------------------------------------------------------------
// reg_file_2r1w
// Register file with two asynchronous read ports and one synchronous write
// port. Contents are not reset.
//   clk              write clock
//   we_i/wa_i/wd_i   write enable, address, data (rising edge)
//   ra_a_i/rd_a_o    read port A
//   ra_b_i/rd_b_o    read port B
// -----------------------------------------------------------------------------
module reg_file_2r1w #(
  parameter  int DATA_W   = 16,
  parameter  int RF_DEPTH = 16,
  localparam int RA_W     = $clog2(RF_DEPTH)
) (
  input  logic              clk,
  input  logic              we_i,
  input  logic [RA_W-1:0]   wa_i,
  input  logic [DATA_W-1:0] wd_i,
  input  logic [RA_W-1:0]   ra_a_i,
  input  logic [RA_W-1:0]   ra_b_i,
  output logic [DATA_W-1:0] rd_a_o,
  output logic [DATA_W-1:0] rd_b_o
);

  logic [DATA_W-1:0] regs_q [RF_DEPTH];

  // NOTE: storage arrays carry no reset so they map onto RAM/LUT resources;
  // software must write a register before relying on its value.
  always_ff @(posedge clk) begin
    if (we_i) begin
      regs_q[wa_i] <= wd_i;
    end
  end

  assign rd_a_o = regs_q[ra_a_i];
  assign rd_b_o = regs_q[ra_b_i];

endmodule

// File: rtl/pipelined_datapath.sv
// -----------------------------------------------------------------------------
// pipelined_datapath
// Two-stage (E, W) pipelined datapath fed by a valid/ready command port.
// A command accepted at edge k executes in E during k..k+1 (RF read, ALU,
// memory address; STORE writes memory at edge k+1, LOAD reads synchronously)
// and writes back in W during k+1..k+2 (RF written at edge k+2). W results
// are forwarded into E, so dependent commands never stall.
//   Clock    system clock, rising edge
//   Reset_n  synchronous active-low reset
//   bus      pipelined_datapath_if.slave (command, status, write-back)
// -----------------------------------------------------------------------------
module pipelined_datapath
  import datapath_pkg::*;
#(
  parameter int DATA_W     = 16,
  parameter int RF_DEPTH   = 16,
  parameter int DMEM_DEPTH = 256
) (
  input  logic Clock,
  input  logic Reset_n,
  pipelined_datapath_if.slave bus
);

  localparam int RA_W = $clog2(RF_DEPTH);
  localparam int MA_W = $clog2(DMEM_DEPTH);
  localparam int MSB  = DATA_W - 1;

  // Command held in E; captured straight from the bus on accept.
  typedef struct packed {
    logic              valid;
    cmd_op_t           op;
    alu_op_t           alu_op;
    logic [DATA_W-1:0] imm;
    logic [MA_W-1:0]   d_addr;
    logic [RA_W-1:0]   w_addr;
    logic [RA_W-1:0]   ra_addr;
    logic [RA_W-1:0]   rb_addr;
  } e_stage_t;

  // Command held in W; data is the LDI immediate or the ALU result.
  // LOAD data arrives separately from the memory read register.
  typedef struct packed {
    logic              valid;
    cmd_op_t           op;
    logic [RA_W-1:0]   w_addr;
    logic [DATA_W-1:0] data;
  } w_stage_t;

  e_stage_t           e_q, e_d;
  w_stage_t           w_q, w_d;
  logic [FLAGS_W-1:0] flags_q, flags_d;

  logic [DATA_W-1:0]  rf_rd_a, rf_rd_b;
  logic [DATA_W-1:0]  op_a, op_b;
  logic [DATA_W-1:0]  alu_res;
  logic [DATA_W:0]    arith_ext;
  logic               alu_carry, alu_ovf;
  logic [DATA_W-1:0]  mem_rdata_q;
  logic [DATA_W-1:0]  wb_data;
  logic               wb_we;
  logic               advance;
  logic               store_we;

  // The pipeline moves on every edge that is neither reset nor held.
  assign advance       = Reset_n & ~bus.Hold;
  assign bus.Cmd_ready = advance;

  // ---------------------------------------------------------------------------
  // Write-back stage outputs
  // ---------------------------------------------------------------------------
  assign wb_we   = w_q.valid & (w_q.op != OP_STORE);
  assign wb_data = (w_q.op == OP_LOAD) ? mem_rdata_q : w_q.data;

  // ---------------------------------------------------------------------------
  // Register file (written from W, read combinationally by E)
  // ---------------------------------------------------------------------------
  reg_file_2r1w #(
    .DATA_W   (DATA_W),
    .RF_DEPTH (RF_DEPTH)
  ) u_rf (
    .clk    (Clock),
    .we_i   (advance & wb_we),
    .wa_i   (w_q.w_addr),
    .wd_i   (wb_data),
    .ra_a_i (e_q.ra_addr),
    .ra_b_i (e_q.rb_addr),
    .rd_a_o (rf_rd_a),
    .rd_b_o (rf_rd_b)
  );

  // ---------------------------------------------------------------------------
  // Operand forwarding: the command in W is always the newest writer, and its
  // RF write has not landed yet, so its data overrides the RF read. Operands
  // are zero while E is empty so an idle or freshly reset pipeline shows 0.
  // ---------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default on entry; a path that leaves
  // a variable unassigned would otherwise infer a latch.
  always_comb begin
    op_a = '0;
    op_b = '0;
    if (e_q.valid) begin
      op_a = (wb_we && (w_q.w_addr == e_q.ra_addr)) ? wb_data : rf_rd_a;
      op_b = (wb_we && (w_q.w_addr == e_q.rb_addr)) ? wb_data : rf_rd_b;
    end
  end

  // ---------------------------------------------------------------------------
  // ALU. Subtract carries "no borrow", i.e. C = 1 when A >= B unsigned.
  // ---------------------------------------------------------------------------
  always_comb begin
    alu_res   = '0;
    arith_ext = '0;
    alu_carry = 1'b0;
    alu_ovf   = 1'b0;
    case (e_q.alu_op)
      ALU_PASS: alu_res = op_a;
      ALU_ADD: begin
        arith_ext = {1'b0, op_a} + {1'b0, op_b};
        alu_res   = arith_ext[MSB:0];
        alu_carry = arith_ext[DATA_W];
        alu_ovf   = (op_a[MSB] == op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_SUB: begin
        arith_ext = {1'b0, op_a} - {1'b0, op_b};
        alu_res   = arith_ext[MSB:0];
        alu_carry = ~arith_ext[DATA_W];
        alu_ovf   = (op_a[MSB] != op_b[MSB]) && (alu_res[MSB] != op_a[MSB]);
      end
      ALU_AND: alu_res = op_a & op_b;
      ALU_OR:  alu_res = op_a | op_b;
      ALU_XOR: alu_res = op_a ^ op_b;
      ALU_NOT: alu_res = ~op_a;
      ALU_INC: begin
        arith_ext = {1'b0, op_a} + {{DATA_W{1'b0}}, 1'b1};
        alu_res   = arith_ext[MSB:0];
        alu_carry = arith_ext[DATA_W];
        alu_ovf   = ~op_a[MSB] & alu_res[MSB];
      end
      default: alu_res = '0;
    endcase
  end

  // Flags change only when an ALU command leaves E.
  always_comb begin
    flags_d = flags_q;
    if (e_q.valid && (e_q.op == OP_ALU)) begin
      flags_d[FLAG_N] = alu_res[MSB];
      flags_d[FLAG_Z] = (alu_res == '0);
      flags_d[FLAG_C] = alu_carry;
      flags_d[FLAG_V] = alu_ovf;
    end
  end

  // ---------------------------------------------------------------------------
  // Next-state for the E and W stage registers
  // ---------------------------------------------------------------------------
  always_comb begin
    e_d.valid   = bus.Cmd_valid & bus.Cmd_ready;
    e_d.op      = bus.Cmd_op;
    e_d.alu_op  = bus.ALU_s0;
    e_d.imm     = bus.Imm;
    e_d.d_addr  = bus.D_Addr;
    e_d.w_addr  = bus.RF_W_Addr;
    e_d.ra_addr = bus.RF_Ra_Addr;
    e_d.rb_addr = bus.RF_Rb_Addr;

    w_d.valid   = e_q.valid;
    w_d.op      = e_q.op;
    w_d.w_addr  = e_q.w_addr;
    w_d.data    = (e_q.op == OP_LDI) ? e_q.imm : alu_res;
  end

  // NOTE: state registers use non-blocking assignments so every register
  // samples its pre-edge inputs regardless of statement order. Reset is
  // synchronous: it is only seen on a rising edge of Clock.
  always_ff @(posedge Clock) begin
    if (!Reset_n) begin
      e_q.valid   <= 1'b0;
      e_q.op      <= OP_LDI;
      e_q.alu_op  <= ALU_PASS;
      e_q.imm     <= '0;
      e_q.d_addr  <= '0;
      e_q.w_addr  <= '0;
      e_q.ra_addr <= '0;
      e_q.rb_addr <= '0;
      w_q.valid   <= 1'b0;
      w_q.op      <= OP_LDI;
      w_q.w_addr  <= '0;
      w_q.data    <= '0;
      flags_q     <= '0;
    end else if (!bus.Hold) begin
      e_q     <= e_d;
      w_q     <= w_d;
      flags_q <= flags_d;
    end
  end

  // ---------------------------------------------------------------------------
  // Data memory: synchronous write of operand A for STORE, synchronous read
  // that lands in W for LOAD. Both freeze under Hold and are blocked on the
  // reset edge so in-flight commands leave no trace.
  // ---------------------------------------------------------------------------
  logic [DATA_W-1:0] dmem [DMEM_DEPTH];

  assign store_we = advance & e_q.valid & (e_q.op == OP_STORE);

  always_ff @(posedge Clock) begin
    if (store_we) begin
      dmem[e_q.d_addr] <= op_a;
    end
    if (advance) begin
      mem_rdata_q <= dmem[e_q.d_addr];
    end
  end

  // ---------------------------------------------------------------------------
  // Outputs
  // ---------------------------------------------------------------------------
  assign bus.ALU_inA  = op_a;
  assign bus.ALU_inB  = op_b;
  assign bus.ALU_out  = e_q.valid ? alu_res : '0;
  assign bus.Flags    = flags_q;
  assign bus.Wb_valid = wb_we;
  assign bus.Wb_addr  = w_q.w_addr;
  assign bus.Wb_data  = wb_data;

endmodule
